fetch_unit: RTL and testbench

- Instruction-fetch stage feeding the instruction memory.
- Owns the program counter and drives the word-aligned byte address on curr_pc.
- Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles stall, flush and branch/jump redirect; counts real fetches; flags fetches outside the instruction window.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 62 ++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: instruction window bounds, NOP encoding and
// the fetch FSM states. Decode and memory import this package as well.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] RESET_PC     = 32'h0040_0000;
  localparam logic [29:0] IMEM_LO_WORD = 30'h0010_0000;
  localparam logic [29:0] IMEM_HI_WORD = 30'h0010_0100;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  // IF/ID update selector: INVAL clears valid but keeps the captured instruction.
  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2,
    IFID_INVAL  = 2'd3
  } ifid_op_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, pc+4 and valid with
// load / hold / bubble / invalidate controls.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ifid_op_e    op_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (op_i)
      IFID_LOAD: begin
        instr_d = instr_i;
        pc4_d   = pc4_i;
        valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      IFID_INVAL: begin
        valid_d = 1'b0;
      end
      IFID_HOLD: begin
        valid_d = valid_q;
      end
      default: begin
        valid_d = valid_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the RUN/HALTED/FAULT state machine,
// the accepted-fetch counter and the instruction-window check.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = RESET_PC,
  parameter logic [29:0] P_LO_WORD  = IMEM_LO_WORD,
  parameter logic [29:0] P_HI_WORD  = IMEM_HI_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt,
  input  logic [31:0] imem_instr,
  output logic [31:0] curr_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic        fault,
  output logic [1:0]  state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         fault_q, fault_d;
  ifid_op_e     ifid_op_s;
  logic         out_of_window_s;
  logic [31:0]  pc_plus4_s;

  assign pc_plus4_s      = pc_q + 32'd4;
  assign out_of_window_s = (pc_q[31:2] < P_LO_WORD) || (pc_q[31:2] > P_HI_WORD);

  // Edge priority in RUN: halt, redirect, window fault, flush, stall, normal fetch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    fault_d   = fault_q;
    ifid_op_s = IFID_HOLD;
    case (state_q)
      RUN: begin
        if (halt) begin
          ifid_op_s = IFID_INVAL;
          state_d   = HALTED;
        end else if (redirect_valid) begin
          ifid_op_s = IFID_BUBBLE;
          if (redirect_target[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            pc_d = redirect_target;
          end
        end else if (!stall && out_of_window_s) begin
          ifid_op_s = IFID_BUBBLE;
          fault_d   = 1'b1;
          state_d   = FAULT;
        end else if (flush) begin
          ifid_op_s = IFID_BUBBLE;
          if (!stall) begin
            pc_d = pc_plus4_s;
          end else begin
            pc_d = pc_q;
          end
        end else if (!stall) begin
          ifid_op_s = IFID_LOAD;
          pc_d      = pc_plus4_s;
          count_d   = count_q + 32'd1;
        end else begin
          ifid_op_s = IFID_HOLD;
        end
      end
      HALTED, FAULT: begin
        ifid_op_s = IFID_HOLD;
      end
      default: begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= P_RESET_PC;
      count_q <= 32'h0000_0000;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .op_i    (ifid_op_s),
    .instr_i (imem_instr),
    .pc4_i   (pc_plus4_s),
    .instr_o (if_id_instr),
    .pc4_o   (if_id_pc4),
    .valid_o (if_id_valid)
  );

  assign curr_pc     = pc_q;
  assign fetch_count = count_q;
  assign fault       = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a rule-level reference model,
// preceded by the directed scenarios from the block's test plan.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect_valid, halt;
  logic [31:0] redirect_target;
  logic [31:0] imem_instr;
  logic [31:0] curr_pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, fault;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  logic        m_valid, m_fault;
  logic [1:0]  m_st;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem_word(curr_pc);

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halt            (halt),
    .imem_instr      (imem_instr),
    .curr_pc         (curr_pc),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count),
    .fault           (fault),
    .state_o         (state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},    curr_pc,               m_pc);
    check({tag, ".instr"}, if_id_instr,           m_instr);
    check({tag, ".pc4"},   if_id_pc4,             m_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid},  {31'd0, m_valid});
    check({tag, ".count"}, fetch_count,           m_count);
    check({tag, ".fault"}, {31'd0, fault},        {31'd0, m_fault});
    check({tag, ".state"}, {30'd0, state_o},      {30'd0, m_st});
  endtask

  task automatic model_reset();
    m_pc = 32'h0040_0000; m_instr = 32'h0; m_pc4 = 32'h0;
    m_valid = 1'b0; m_count = 32'h0; m_fault = 1'b0; m_st = 2'd0;
  endtask

  // Next-state rules of the fetch stage, stated directly from the behaviour list.
  task automatic model_edge(input logic s, input logic f, input logic rv,
                            input logic [31:0] t, input logic h);
    int unsigned word;
    word = m_pc >> 2;
    if (m_st != 2'd0) return;
    if (h) begin
      m_valid = 1'b0; m_st = 2'd1;
    end else if (rv) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (t % 4 != 0) begin m_fault = 1'b1; m_st = 2'd2; end
      else m_pc = t;
    end else if (!s && (word < 32'h0010_0000 || word > 32'h0010_0100)) begin
      m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b1; m_st = 2'd2;
    end else if (f) begin
      m_instr = 32'h0; m_valid = 1'b0;
      if (!s) m_pc = m_pc + 4;
    end else if (!s) begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1;
      m_count = m_count + 1; m_pc = m_pc + 4;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic s, input logic f, input logic rv,
                      input logic [31:0] t, input logic h);
    stall = s; flush = f; redirect_valid = rv; redirect_target = t; halt = h;
    model_edge(s, f, rv, t, h);
    @(posedge clk);
    #1;
    compare_all("cyc");
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    logic        s, f, rv, h;
    int          r;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'h0; halt = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all("init");
    rst = 1'b0;

    // Three free-running fetches.
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp1.instrA", if_id_instr, mem_word(32'h0040_0000));
    check("tp1.pc4A",   if_id_pc4,   32'h0040_0004);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp1.instrC", if_id_instr, mem_word(32'h0040_0008));
    check("tp1.pc4C",   if_id_pc4,   32'h0040_000C);
    check("tp1.count",  fetch_count, 32'd3);

    // Stall held two cycles after the first fetch.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp2.pc",    curr_pc,     32'h0040_0004);
    check("tp2.instr", if_id_instr, mem_word(32'h0040_0000));
    check("tp2.count", fetch_count, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp2.resume", if_id_instr, mem_word(32'h0040_0004));

    // Redirect during stall, then fetch at the target.
    step(1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b0);
    check("tp3.pc",    curr_pc,               32'h0040_0100);
    check("tp3.valid", {31'd0, if_id_valid},  32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp3.fetch", if_id_instr, mem_word(32'h0040_0100));

    // Misaligned redirect faults; later redirects ignored.
    step(1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b0);
    check("tp4.state", {30'd0, state_o}, 32'd2);
    check("tp4.pc",    curr_pc,          32'h0040_0104);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b0);
    check("tp4.ignored", curr_pc, 32'h0040_0104);

    // Top of the window is legal, one word past it faults.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 32'h0040_0400, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp5.count", fetch_count, 32'd1);
    check("tp5.pc",    curr_pc,     32'h0040_0404);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    check("tp5.fault", {31'd0, fault}, 32'd1);
    check("tp5.nocnt", fetch_count,    32'd1);

    // Halt beats redirect, then async reset mid-cycle.
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b1);
    check("tp6.state", {30'd0, state_o}, 32'd1);
    check("tp6.pc",    curr_pc,          32'h0040_0004);
    check("tp6.keep",  if_id_instr,      mem_word(32'h0040_0000));
    do_reset();
    check("tp6.rstpc", curr_pc, 32'h0040_0000);

    for (int i = 0; i < 3000; i++) begin
      if ((m_st != 2'd0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        s  = ($urandom_range(0, 3) == 0);
        f  = ($urandom_range(0, 5) == 0);
        rv = ($urandom_range(0, 11) == 0);
        h  = ($urandom_range(0, 149) == 0);
        r  = $urandom_range(0, 9);
        tgt = 32'h0040_0000 + (32'($urandom_range(0, 256)) << 2);
        if (r == 0) tgt = tgt + 32'($urandom_range(1, 3));
        else if (r == 1) tgt = 32'h0040_0404 + (32'($urandom_range(0, 15)) << 2);
        else if (r == 2) tgt = 32'h003F_FFFC;
        step(s, f, rv, tgt, h);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
